// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns one raw PWM into complementary PWMH/PWML gate drives with
// programmable rise/fall dead time. Define PWM_DEADTIME_FAULT_EN to add the fault path.
module pwm_deadtime (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       PWMIN,
  input  logic [7:0] DT_RISE,
  input  logic [7:0] DT_FALL,
  input  logic       POL_H,
  input  logic       POL_L,
  input  logic       FAULT,
  input  logic       FAULT_CLR,
  output logic       FAULTF,
  output logic       PWMH,
  output logic       PWML
);

`ifdef PWM_DEADTIME_FAULT_EN
  typedef enum logic [2:0] {OFF, LO, DTR, HI, DTF, FLT} state_t;
`else
  typedef enum logic [2:0] {OFF, LO, DTR, HI, DTF} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       pwm_q;
  logic       hi_act, lo_act;

  // Single input register: timer/comparator glitches never reach the decision logic.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= PWMIN;
  end

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_meta, fault_sync, faultf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta <= 1'b0;
      fault_sync <= 1'b0;
    end else begin
      fault_meta <= FAULT;
      fault_sync <= fault_meta;
    end
  end

  // A live fault beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          faultf_q <= 1'b0;
    else if (fault_sync) faultf_q <= 1'b1;
    else if (FAULT_CLR)  faultf_q <= 1'b0;
  end

  assign FAULTF = faultf_q;
`else
  logic unused_fault;
  assign unused_fault = ^{FAULT, FAULT_CLR};
  assign FAULTF       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; priority is fault detect > fault hold > disable > normal.
  always_comb begin
    // NOTE: defaulting every always_comb output first prevents inferred latches.
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef PWM_DEADTIME_FAULT_EN
    if (fault_sync) begin
      state_nxt = FLT;
      cnt_nxt   = '0;
    end else if (state == FLT) begin
      if (!faultf_q) state_nxt = OFF;
    end else
`endif
    if (!EN) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          if (pwm_q) begin
            state_nxt = DTR;
            cnt_nxt   = DT_RISE;
          end else begin
            state_nxt = DTF;
            cnt_nxt   = DT_FALL;
          end
        end
        LO: begin
          if (pwm_q) begin
            state_nxt = DTR;
            cnt_nxt   = DT_RISE;
          end
        end
        HI: begin
          if (!pwm_q) begin
            state_nxt = DTF;
            cnt_nxt   = DT_FALL;
          end
        end
        // A reversal inside the gap returns straight to the side already off-going,
        // so the short pulse is swallowed without adding a second gap.
        DTR: begin
          if (!pwm_q) begin
            state_nxt = LO;
            cnt_nxt   = '0;
          end else if (cnt == 8'd0) begin
            state_nxt = HI;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        DTF: begin
          if (pwm_q) begin
            state_nxt = HI;
            cnt_nxt   = '0;
          end else if (cnt == 8'd0) begin
            state_nxt = LO;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: each side is active in exactly one state, so overlap is impossible.
  always_comb begin
    hi_act = (state == HI);
    lo_act = (state == LO);
  end

  assign PWMH = POL_H ? hi_act : ~hi_act;
  assign PWML = POL_L ? lo_act : ~lo_act;

  a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n) !(hi_act && lo_act));

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: gap timing, pulse swallowing, enable, polarity,
// reset abort, the fault path (when PWM_DEADTIME_FAULT_EN is defined) and a random overlap sweep.
module tb_pwm_deadtime;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pwmin;
  logic [7:0] dt_rise;
  logic [7:0] dt_fall;
  logic       pol_h;
  logic       pol_l;
  logic       fault;
  logic       fault_clr;
  logic       faultf;
  logic       pwmh;
  logic       pwml;

  int total = 0;
  int bad   = 0;

  pwm_deadtime dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (en),
    .PWMIN     (pwmin),
    .DT_RISE   (dt_rise),
    .DT_FALL   (dt_fall),
    .POL_H     (pol_h),
    .POL_L     (pol_l),
    .FAULT     (fault),
    .FAULT_CLR (fault_clr),
    .FAULTF    (faultf),
    .PWMH      (pwmh),
    .PWML      (pwml)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles; step i is compared with the i-th 3-bit group {FAULTF,PWMH,PWML}, MSB group first.
  task automatic run_seq(input string name, input int n, input logic [47:0] seq);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s[%0d]", name, i), {29'd0, faultf, pwmh, pwml},
            {29'd0, seq[3*(n-1-i) +: 3]});
    end
  endtask

  int overlap;
  int hi_seen;
  int lo_seen;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    pwmin     = 1'b0;
    dt_rise   = 8'd3;
    dt_fall   = 8'd2;
    pol_h     = 1'b1;
    pol_l     = 1'b1;
    fault     = 1'b0;
    fault_clr = 1'b0;

    // Reset state, active-high polarity: both low, no fault.
    tick();
    check("rst_state", {29'd0, faultf, pwmh, pwml}, 32'd0);
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("settle_lo", {29'd0, faultf, pwmh, pwml}, 32'b001);

    // DT_RISE=3: PWML drops two edges after the input change, PWMH rises four cycles later.
    // DT_RISE is changed mid-gap and must not stretch it.
    pwmin = 1'b1;
    run_seq("rise_gap_a", 3, 9'b001_000_000);
    dt_rise = 8'd50;
    run_seq("rise_gap_b", 3, 9'b000_000_010);
    dt_rise = 8'd3;

    // DT_FALL=0: exactly one both-off cycle.
    dt_fall = 8'd0;
    pwmin   = 1'b0;
    run_seq("fall_dt0", 4, 12'b010_000_001_001);

    // DT_RISE=10 with a 3-cycle pulse: PWMH never asserts, PWML resumes immediately.
    dt_rise = 8'd10;
    pwmin   = 1'b1;
    run_seq("swallow_hi_a", 3, 9'b001_000_000);
    pwmin = 1'b0;
    run_seq("swallow_hi_b", 12, 36'b000_001_001_001_001_001_001_001_001_001_001_001);

    // Reach HI with DT_RISE=1, then swallow a 2-cycle low pulse inside a 10-cycle fall gap.
    dt_rise = 8'd1;
    dt_fall = 8'd10;
    pwmin   = 1'b1;
    run_seq("to_hi", 4, 12'b001_000_000_010);
    pwmin = 1'b0;
    run_seq("swallow_lo_a", 2, 6'b010_000);
    pwmin = 1'b1;
    run_seq("swallow_lo_b", 3, 9'b000_010_010);

    // EN=0 forces OFF at once; re-enabling restarts through a rise gap.
    en = 1'b0;
    run_seq("en_off", 2, 6'b000_000);
    en = 1'b1;
    run_seq("en_on", 3, 9'b000_000_010);

`ifdef PWM_DEADTIME_FAULT_EN
    // Fault during HI: outputs off on the third edge, clear while fault high is ignored,
    // EN has no effect in FLT, and recovery runs through OFF.
    fault = 1'b1;
    run_seq("flt_enter", 3, 9'b010_010_100);
    fault_clr = 1'b1;
    run_seq("flt_clr_blocked", 1, 3'b100);
    fault_clr = 1'b0;
    en        = 1'b0;
    run_seq("flt_en_low", 1, 3'b100);
    en    = 1'b1;
    fault = 1'b0;
    run_seq("flt_drain", 3, 9'b100_100_100);
    fault_clr = 1'b1;
    run_seq("flt_clr", 1, 3'b000);
    fault_clr = 1'b0;
    run_seq("flt_exit", 4, 12'b000_000_000_010);
`else
    // Without the fault option the fault inputs are ignored.
    fault = 1'b1;
    run_seq("nofault_ign", 3, 9'b010_010_010);
    fault_clr = 1'b1;
    run_seq("nofault_clr", 1, 3'b010);
    fault     = 1'b0;
    fault_clr = 1'b0;
`endif

    // Reset asserted mid fall gap: outputs stay off immediately.
    pwmin = 1'b0;
    run_seq("pre_rst", 2, 6'b010_000);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dt", {29'd0, faultf, pwmh, pwml}, 32'b000);
    tick();
    check("rst_hold", {29'd0, faultf, pwmh, pwml}, 32'b000);

    // Active-low polarity: inactive is 1. Then release with EN=1, PWMIN=0, DT_FALL=2.
    pol_h = 1'b0;
    pol_l = 1'b0;
    en    = 1'b0;
    #1;
    check("pol0_rst", {29'd0, faultf, pwmh, pwml}, 32'b011);
    rst_n = 1'b1;
    run_seq("pol0_en0", 2, 6'b011_011);
    rst_n   = 1'b0;
    en      = 1'b1;
    dt_fall = 8'd2;
    #1;
    check("pol0_rst2", {29'd0, faultf, pwmh, pwml}, 32'b011);
    tick();
    rst_n = 1'b1;
    run_seq("pol0_release", 4, 12'b011_011_011_010);

    // Random sweep: PWMH and PWML must never be active together.
    overlap = 0;
    hi_seen = 0;
    lo_seen = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ((pwmh == pol_h) && (pwml == pol_l)) overlap++;
      if (pwmh == pol_h) hi_seen++;
      if (pwml == pol_l) lo_seen++;
      if ($urandom_range(0, 7) == 0)   pwmin = ~pwmin;
      if ($urandom_range(0, 63) == 0) begin
        dt_rise = 8'($urandom_range(0, 7));
        dt_fall = 8'($urandom_range(0, 7));
      end
      en = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 199) == 0) fault = ~fault;
      fault_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        pol_h = 1'($urandom_range(0, 1));
        pol_l = 1'($urandom_range(0, 1));
      end
    end
    check("rand_no_overlap", overlap, 32'd0);
    check("rand_hi_seen", {31'd0, hi_seen != 0}, 32'd1);
    check("rand_lo_seen", {31'd0, lo_seen != 0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
